pixel_stream_packer: RTL
========================

// Module: pixel_stream_packer
// PURPOSE
//  Synthesizable producer of the image word stream that the host reads from SD: header words, filtered pixels
//  (thumbnailing by keep/period decimation), Fletcher-32 checksum, zero padding. Every word is emitted little-endian
//  on the wire. Sits between the image pipeline/header source and the SD write path.
// PARAMETERS
//  HeaderWordCount   8     16-bit header words taken from hdr_* before pixels (0 allowed)
//  ImageWidth        2304  full-resolution pixels per row arriving on pix_*
//  ImageHeight       1296  full-resolution rows arriving on pix_*
//  FilterPeriod      1     decimation period in x and y (ImageWidth, ImageHeight must be multiples)
//  FilterKeep        1     pixels/rows kept at start of each period (1..FilterPeriod)
//  PaddingWordCount  0     0x0000 words appended after checksum
// PORTS
//  clk        in   1   single clock
//  rst        in   1   synchronous, active-high reset
//  start      in   1   1-cycle pulse: begin a frame (ignored unless idle)
//  busy       out  1   high from cycle after accepted start until last word handshaken
//  done       out  1   1-cycle pulse on the cycle after the last output handshake
//  hdr_valid  in   1   header word available
//  hdr_ready  out  1   header word accepted when hdr_valid&&hdr_ready
//  hdr_data   in   16  header word, host order
//  pix_valid  in   1   full-res pixel available, raster order
//  pix_ready  out  1   pixel accepted (kept or dropped) when pix_valid&&pix_ready
//  pix_data   in   16  pixel, host order
//  out_valid  out  1   output word valid
//  out_ready  in   1   downstream accepts when out_valid&&out_ready
//  out_data   out  16  wire word (byte-swapped from host order)
// BEHAVIOUR
//  Reset: out_valid=0, out_data=0, busy=0, done=0, hdr_ready=0, pix_ready=0; FSM=IDLE; counters, Fletcher sums=0.
//  FSM: IDLE -start-> HEADER (or PIXELS if HeaderWordCount==0) -> PIXELS -> CK0 -> CK1 -> PAD (skipped if 0) -> IDLE.
//  Output register: one-deep; load allowed when !out_valid || out_ready (load_en). out_data/out_valid held
//   stable while out_valid&&!out_ready. Full throughput: 1 word/cycle with out_ready=1.
//  HEADER: hdr_ready=load_en; accepted word -> out_data=swap16(hdr_data); after HeaderWordCount words -> PIXELS.
//  PIXELS: x/y counters over ImageWidth x ImageHeight. keep = (x%FilterPeriod<FilterKeep)&&(y%FilterPeriod<FilterKeep).
//   pix_ready = keep ? load_en : 1 (dropped pixels consumed at 1/cycle, no output). Kept -> out_data=swap16(pix_data).
//   After last full-res pixel accepted -> CK0. Kept count = (W*K/P)*(H*K/P).
//  Checksum: Fletcher-32 over host-order value of every header and kept pixel word, in emit order, updated on load:
//   A'=(A+d) mod 65535, B'=(B+A') mod 65535, both held in [0,65534]; result C={B,A}. Single-cycle update.
//  CK0: emits {C[7:0],C[15:8]}; CK1: emits {C[23:16],C[31:24]} (little-endian uint32 on the wire).
//  PAD: PaddingWordCount words of 0x0000. Frame length = Header+kept+2+Padding words.
//  done pulses after final handshake; busy drops same cycle; start in that cycle ignored, next cycle accepted.
//  hdr_ready=0 outside HEADER, pix_ready=0 outside PIXELS; excess upstream data is left untouched.
//  start while busy ignored. rst mid-frame: immediate return to reset state, in-flight out word discarded.
//  Counters sized $clog2(max+1); no wrap within a frame; wrap of sums via mod 65535 (0xFFFF reduces to 0).
// STRUCTURE
//  Package pixel_stream_pkg: FSM state enum, swap16 function, FLETCHER_MOD=16'hFFFF.
//  Sub-module fletcher32_accum (clk, rst, clear, en, din[15:0], sum[31:0]); FSM, counters, output reg in top.
// TESTING
//  H=0,W=2,Ht=1,P=K=1,Pad=0; pixels 0x0102,0x0304 -> out 0x0201,0x0403,0x0604,0x0805; done after 4th.
//  H=2 (0x0001,0x0002),W=1,Ht=1,pix 0xFFFF,Pad=3 -> 0x0100,0x0200,0xFFFF,cs words,0x0000 x3; Fletcher mod check.
//  W=Ht=4,P=2,K=1, pix value=index -> kept 0x0000,0x0002,0x0008,0x000A (swapped), 16 pix accepted, 6 words out.
//  Random out_ready (50%), stalls on pix/hdr -> identical word sequence to no-stall run; out_data stable when stalled.
//  rst asserted mid-PIXELS -> next cycle all outputs 0, busy=0; new start yields full correct frame from word 0.
//  start pulsed while busy and in done cycle -> ignored; exactly one frame emitted.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_pkg
// Description : Shared types and helpers for the pixel stream packer: FSM
//               state encoding, host-to-wire byte swap, Fletcher modulus.
// Revision    : 1.0 - initial release
// ============================================================================
package pixel_stream_pkg;

    // Fletcher-32 works modulo 2^16-1; 0xFFFF reduces to 0.
    localparam logic [15:0] FLETCHER_MOD = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_PIXELS = 3'd2,
        ST_CK0    = 3'd3,
        ST_CK1    = 3'd4,
        ST_PAD    = 3'd5
    } stateT;

    // Host-order word to little-endian wire word.
    function automatic logic [15:0] swap16(input logic [15:0] word);
        return {word[7:0], word[15:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fletcher32_accum.sv
`default_nettype none
// ============================================================================
// Module      : fletcher32_accum
// Description : Fletcher-32 running sums. One 16-bit word folded in per
//               enabled cycle; both sums kept in [0, 65534].
// Revision    : 1.0 - initial release
// ============================================================================
module fletcher32_accum
    import pixel_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic [15:0] din,
    output logic [31:0] sum
);

    logic [15:0] r_sumA;
    logic [15:0] r_sumB;
    logic [15:0] w_nextA;
    logic [15:0] w_nextB;

    // (a + b) mod 65535 for a in [0,65534], b in [0,65535]; one subtract suffices.
    function automatic logic [15:0] modAdd(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, FLETCHER_MOD}) begin
            s = s - {1'b0, FLETCHER_MOD};
        end
        return s[15:0];
    endfunction

    // Next sums: B folds in the already-updated A.
    always_comb begin
        w_nextA = modAdd(r_sumA, din);
        w_nextB = modAdd(r_sumB, w_nextA);
    end

    // Sum registers, cleared at frame start.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_sumA <= 16'h0000;
            r_sumB <= 16'h0000;
        end else if (en) begin
            r_sumA <= w_nextA;
            r_sumB <= w_nextB;
        end
    end

    assign sum = {r_sumB, r_sumA};

endmodule
`default_nettype wire

// File: rtl/pixel_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : pixel_stream_packer
// Description : Builds the SD image word stream: header words, decimated
//               pixels, Fletcher-32 checksum and zero padding, byte-swapped
//               to little-endian, through a one-deep output register.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_stream_packer
    import pixel_stream_pkg::*;
#(
    parameter int HEADER_WORD_COUNT  = 8,
    parameter int IMAGE_WIDTH        = 2304,
    parameter int IMAGE_HEIGHT       = 1296,
    parameter int FILTER_PERIOD      = 1,
    parameter int FILTER_KEEP        = 1,
    parameter int PADDING_WORD_COUNT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [15:0] hdr_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data
);

    localparam int c_HDR_W = (HEADER_WORD_COUNT > 0) ? $clog2(HEADER_WORD_COUNT + 1) : 1;
    localparam int c_X_W   = $clog2(IMAGE_WIDTH + 1);
    localparam int c_Y_W   = $clog2(IMAGE_HEIGHT + 1);
    localparam int c_PH_W  = $clog2(FILTER_PERIOD + 1);
    localparam int c_PAD_W = (PADDING_WORD_COUNT > 0) ? $clog2(PADDING_WORD_COUNT + 1) : 1;

    localparam logic [c_HDR_W-1:0] c_HDR_LAST = c_HDR_W'((HEADER_WORD_COUNT > 0) ? HEADER_WORD_COUNT - 1 : 0);
    localparam logic [c_X_W-1:0]   c_X_LAST   = c_X_W'(IMAGE_WIDTH - 1);
    localparam logic [c_Y_W-1:0]   c_Y_LAST   = c_Y_W'(IMAGE_HEIGHT - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(FILTER_PERIOD - 1);
    localparam logic [c_PH_W-1:0]  c_KEEP     = c_PH_W'(FILTER_KEEP);
    localparam logic [c_PAD_W-1:0] c_PAD_LAST = c_PAD_W'((PADDING_WORD_COUNT > 0) ? PADDING_WORD_COUNT - 1 : 0);

    stateT               r_state;
    stateT               w_nextState;

    logic [c_HDR_W-1:0]  r_hdrCnt;
    logic [c_X_W-1:0]    r_x;
    logic [c_Y_W-1:0]    r_y;
    logic [c_PH_W-1:0]   r_xPh;
    logic [c_PH_W-1:0]   r_yPh;
    logic [c_PAD_W-1:0]  r_padCnt;

    logic                r_outValid;
    logic [15:0]         r_outData;
    logic                r_outLast;
    logic                r_busy;
    logic                r_done;

    logic                w_loadEn;
    logic                w_load;
    logic [15:0]         w_loadData;
    logic                w_loadLast;
    logic                w_sumEn;
    logic [15:0]         w_sumDin;
    logic [31:0]         w_sum;
    logic                w_keep;
    logic                w_hdrReady;
    logic                w_pixReady;
    logic                w_hdrAcc;
    logic                w_pixAcc;
    logic                w_lastPix;
    logic                w_startAcc;
    logic                w_lastHandshake;

    // The output register may take a new word when empty or being drained.
    assign w_loadEn        = !r_outValid || out_ready;
    assign w_keep          = (r_xPh < c_KEEP) && (r_yPh < c_KEEP);
    assign w_lastPix       = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_hdrAcc        = hdr_valid && w_hdrReady;
    assign w_pixAcc        = pix_valid && w_pixReady;
    // A start in the done cycle is dropped; busy/done both low means truly idle.
    assign w_startAcc      = start && (r_state == ST_IDLE) && !r_busy && !r_done;
    assign w_lastHandshake = r_outValid && out_ready && r_outLast;

    // Next-state, upstream ready and output-register load selection.
    always_comb begin
        w_nextState = r_state;
        w_hdrReady  = 1'b0;
        w_pixReady  = 1'b0;
        w_load      = 1'b0;
        w_loadData  = 16'h0000;
        w_loadLast  = 1'b0;
        w_sumEn     = 1'b0;
        w_sumDin    = 16'h0000;
        case (r_state)
            ST_IDLE: begin
                if (w_startAcc) begin
                    w_nextState = (HEADER_WORD_COUNT > 0) ? ST_HEADER : ST_PIXELS;
                end
            end
            ST_HEADER: begin
                w_hdrReady = w_loadEn;
                if (hdr_valid && w_loadEn) begin
                    w_load     = 1'b1;
                    w_loadData = swap16(hdr_data);
                    w_sumEn    = 1'b1;
                    w_sumDin   = hdr_data;
                    if (r_hdrCnt == c_HDR_LAST) begin
                        w_nextState = ST_PIXELS;
                    end
                end
            end
            ST_PIXELS: begin
                // Dropped pixels need no output slot, so they drain every cycle.
                w_pixReady = w_keep ? w_loadEn : 1'b1;
                if (pix_valid && w_pixReady) begin
                    if (w_keep) begin
                        w_load     = 1'b1;
                        w_loadData = swap16(pix_data);
                        w_sumEn    = 1'b1;
                        w_sumDin   = pix_data;
                    end
                    if (w_lastPix) begin
                        w_nextState = ST_CK0;
                    end
                end
            end
            ST_CK0: begin
                if (w_loadEn) begin
                    w_load      = 1'b1;
                    w_loadData  = swap16(w_sum[15:0]);
                    w_nextState = ST_CK1;
                end
            end
            ST_CK1: begin
                if (w_loadEn) begin
                    w_load      = 1'b1;
                    w_loadData  = swap16(w_sum[31:16]);
                    w_loadLast  = (PADDING_WORD_COUNT == 0);
                    w_nextState = (PADDING_WORD_COUNT == 0) ? ST_IDLE : ST_PAD;
                end
            end
            ST_PAD: begin
                if (w_loadEn) begin
                    w_load     = 1'b1;
                    w_loadData = 16'h0000;
                    if (r_padCnt == c_PAD_LAST) begin
                        w_loadLast  = 1'b1;
                        w_nextState = ST_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Frame position counters; x/y phases track the decimation period without dividers.
    always_ff @(posedge clk) begin
        if (rst || w_startAcc) begin
            r_hdrCnt <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_xPh    <= '0;
            r_yPh    <= '0;
            r_padCnt <= '0;
        end else begin
            if (w_hdrAcc) begin
                r_hdrCnt <= r_hdrCnt + 1'b1;
            end
            if (w_pixAcc) begin
                if (r_x == c_X_LAST) begin
                    r_x   <= '0;
                    r_xPh <= '0;
                    r_y   <= r_y + 1'b1;
                    r_yPh <= (r_yPh == c_PH_LAST) ? '0 : r_yPh + 1'b1;
                end else begin
                    r_x   <= r_x + 1'b1;
                    r_xPh <= (r_xPh == c_PH_LAST) ? '0 : r_xPh + 1'b1;
                end
            end
            if ((r_state == ST_PAD) && w_loadEn) begin
                r_padCnt <= r_padCnt + 1'b1;
            end
        end
    end

    // One-deep output register; holds its word while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid <= 1'b0;
            r_outData  <= 16'h0000;
            r_outLast  <= 1'b0;
        end else if (w_loadEn) begin
            r_outValid <= w_load;
            if (w_load) begin
                r_outData <= w_loadData;
                r_outLast <= w_loadLast;
            end
        end
    end

    // Frame status: busy spans accept-to-last-handshake, done pulses right after.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_lastHandshake;
            if (w_startAcc) begin
                r_busy <= 1'b1;
            end else if (w_lastHandshake) begin
                r_busy <= 1'b0;
            end
        end
    end

    fletcher32_accum u_fletcher (
        .clk   (clk),
        .rst   (rst),
        .clear (w_startAcc),
        .en    (w_sumEn),
        .din   (w_sumDin),
        .sum   (w_sum)
    );

    assign hdr_ready = w_hdrReady;
    assign pix_ready = w_pixReady;
    assign out_valid = r_outValid;
    assign out_data  = r_outData;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
